vga_line_fetch: RTL
===================

// Module: vga_line_fetch
// PURPOSE
//  Wishbone pipelined bus master feeding the text/pixel generator of the VGA
//  block. On each line_start_i it reads WORDS consecutive 32-bit words from
//  video memory at line_base_i into one bank of a double-buffered line RAM,
//  while the generator reads the other bank. Single clock domain.
// PARAMETERS
//  WORDS    80  words fetched per line (1..2**BUF_AW)
//  BUF_AW   7   line-buffer word address width per bank
//  MAX_OUT  4   max outstanding (issued, unacked) bus requests, 1..8
// PORTS
//  clk_i        in   1       system clock
//  rst_ni       in   1       synchronous active-low reset
//  line_start_i in   1       1-cycle pulse: swap banks, start fetch
//  line_base_i  in   32      byte address of first word, sampled on line_start_i
//  busy_o       out  1       fetch in progress
//  done_o       out  1       1-cycle pulse when fetch completes
//  err_o        out  1       sticky: wb_err_i seen during current fetch
//  overrun_o    out  1       1-cycle pulse: line_start_i while busy_o
//  bank_o       out  1       bank being filled; generator reads ~bank_o
//  wb_cyc_o     out  1       bus cycle
//  wb_stb_o     out  1       request strobe
//  wb_adr_o     out  32      byte address, [1:0]=0
//  wb_we_o      out  1       constant 0
//  wb_sel_o     out  4       constant 4'hf
//  wb_dat_i     in   32      read data
//  wb_ack_i     in   1       request acknowledge
//  wb_err_i     in   1       request error termination
//  wb_stall_i   in   1       slave cannot accept request this cycle
//  rd_adr_i     in   BUF_AW  generator read address into bank ~bank_o
//  rd_dat_o     out  32      read data, registered, 1-cycle latency
// BEHAVIOUR
//  Reset (rst_ni=0 at clk edge): state IDLE; busy_o, done_o, err_o, overrun_o,
//   wb_cyc_o, wb_stb_o = 0; bank_o=0; wb_adr_o=0; counters cleared. Buffer
//   RAM contents not reset; rd_dat_o undefined until first read after reset.
//  Reset mid-fetch: cyc/stb drop on the next edge; late acks ignored.
//  States: IDLE -> FETCH on line_start_i (bank_o toggles, base latched,
//   err_o cleared, issued=acked=0, busy_o=1 from next cycle).
//   FETCH: stb_o=1 while issued<WORDS and (issued-acked)<MAX_OUT and no
//    error seen. A request is accepted when stb_o & ~wb_stall_i; then
//    issued++ and adr advances by 4. wb_adr_o = base + 4*issued; base[1:0]
//    ignored (forced 0). 32-bit address wraps modulo 2**32.
//   Each wb_ack_i writes wb_dat_i to bank_o at index acked, acked++.
//   wb_err_i: counts as termination (acked++, word written as 0), sets err_o,
//    stops further issue; FETCH -> DRAIN.
//   FETCH -> DONE when acked==WORDS. DRAIN -> DONE when acked==issued.
//   DONE (1 cycle): done_o=1, cyc=0, busy_o=0; -> IDLE.
//  wb_cyc_o=1 throughout FETCH/DRAIN, including cycles with no stb.
//  Ack/err with no outstanding request: ignored.
//  Simultaneous accept and ack in one cycle: both counters update; outstanding
//   count unchanged.
//  line_start_i while busy_o: ignored (no bank swap), overrun_o pulses.
//  line_start_i in the DONE cycle: accepted, next state FETCH.
//  Read port: rd_dat_o <= buf[~bank_o][rd_adr_i] each cycle; rd_adr_i>=WORDS
//   returns stale/undefined data. Bank swap takes effect for reads issued on
//   the cycle after line_start_i.
//  Throughput: zero-wait slave with no stall -> 1 word/cycle; WORDS=80
//   completes in 80+latency cycles.
// TESTING
//  1 Reset, base=0x1000, zero-wait acking slave -> 80 reads 0x1000..0x113C in
//    order, done_o once, bank_o=1, buffer bank1 matches memory.
//  2 Slave stalls every other cycle, ack latency 3 -> never >4 outstanding,
//    all 80 words correct, adr sequence without gaps or repeats.
//  3 wb_err_i on 10th request -> err_o=1, no new stb, cyc held until all
//    outstanding terminate, word 9 = 0, done_o pulses.
//  4 line_start_i while busy -> overrun_o pulse, bank_o unchanged, fetch
//    continues to done.
//  5 Second line after first: generator reads bank1 (rd_adr=5 -> word 5,
//    1-cycle latency) while bank0 fills; no corruption of bank1.
//  6 rst_ni low mid-fetch (20 words issued) -> cyc/stb 0 next edge, outputs at
//    reset values; a new line after reset fetches cleanly.

Source files
------------

// File: rtl/vga_line_fetch_if.sv
// Pipelined Wishbone read channel between the line fetcher (master) and video memory (slave).
interface vga_line_fetch_if;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (output cyc, stb, adr, we, sel, input dat, ack, err, stall);
    modport slave  (input cyc, stb, adr, we, sel, output dat, ack, err, stall);
endinterface

// File: rtl/vga_line_fetch.sv
// Fetches one video line per line_start_i over pipelined Wishbone into a
// double-buffered line RAM; the pixel generator reads the bank not being filled.
module vga_line_fetch #(
    parameter int WORDS   = 80,
    parameter int BUF_AW  = 7,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 line_start_i,
    input  logic [31:0]          line_base_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 overrun_o,
    output logic                 bank_o,
    vga_line_fetch_if.master     wb,
    input  logic [BUF_AW-1:0]    rd_adr_i,
    output logic [31:0]          rd_dat_o
);
    localparam int CW = BUF_AW + 1;
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   issued_reg, issued_next;
    logic [CW-1:0]   acked_reg, acked_next;
    logic [CW-1:0]   outstanding_next;
    logic [31:0]     adr_reg, adr_next;
    logic            bank_reg, bank_next;
    logic            err_reg, err_next;
    logic            stb_reg, cyc_reg, busy_reg, done_reg, overrun_reg;
    logic            accept, term, term_err, start_ok;

    logic [31:0] line_buf [0:(2**CW)-1];

    // Terminations only count against requests actually in flight.
    assign accept   = stb_reg & ~wb.stall;
    assign term     = cyc_reg & (wb.ack | wb.err) & (issued_reg != acked_reg);
    assign term_err = term & wb.err;
    assign start_ok = line_start_i & ~busy_reg;

    always_comb begin
        state_next  = state_reg;
        issued_next = issued_reg + CW'(accept);
        acked_next  = acked_reg + CW'(term);
        adr_next    = accept ? adr_reg + 32'd4 : adr_reg;
        bank_next   = bank_reg;
        err_next    = err_reg | term_err;
        case (state_reg)
            FETCH: begin
                if (term_err)
                    state_next = DRAIN;
                else if (acked_next == WORDS_C)
                    state_next = DONE;
            end
            DRAIN: begin
                if (acked_next == issued_next)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start_ok) begin
            state_next  = FETCH;
            bank_next   = ~bank_reg;
            adr_next    = line_base_i & 32'hFFFF_FFFC;
            issued_next = '0;
            acked_next  = '0;
            err_next    = 1'b0;
        end
    end

    assign outstanding_next = issued_next - acked_next;

    // Bus outputs are registered from next-state values so they line up with the counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            issued_reg  <= '0;
            acked_reg   <= '0;
            adr_reg     <= '0;
            bank_reg    <= 1'b0;
            err_reg     <= 1'b0;
            stb_reg     <= 1'b0;
            cyc_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            issued_reg  <= issued_next;
            acked_reg   <= acked_next;
            adr_reg     <= adr_next;
            bank_reg    <= bank_next;
            err_reg     <= err_next;
            cyc_reg     <= (state_next == FETCH) || (state_next == DRAIN);
            busy_reg    <= (state_next == FETCH) || (state_next == DRAIN);
            done_reg    <= (state_next == DONE);
            stb_reg     <= (state_next == FETCH) && (issued_next < WORDS_C)
                           && (outstanding_next < MAX_C);
            overrun_reg <= line_start_i & busy_reg;
        end
    end

    // Errored words are stored as zero so the generator never shows stale data.
    always_ff @(posedge clk_i) begin
        if (term && rst_ni)
            line_buf[{bank_reg, acked_reg[BUF_AW-1:0]}] <= wb.err ? 32'd0 : wb.dat;
        rd_dat_o <= line_buf[{~bank_reg, rd_adr_i}];
    end

    assign wb.cyc    = cyc_reg;
    assign wb.stb    = stb_reg;
    assign wb.adr    = adr_reg;
    assign wb.we     = 1'b0;
    assign wb.sel    = 4'hf;
    assign busy_o    = busy_reg;
    assign done_o    = done_reg;
    assign err_o     = err_reg;
    assign overrun_o = overrun_reg;
    assign bank_o    = bank_reg;
endmodule
